// File: rtl/mem_access_unit.sv
// Memory-access stage between ex and wb: drives a req/ack data bus, splits boundary-crossing accesses,
// stalls upstream while a bus transaction is outstanding. Results are registered toward wb/id.
module mem_access_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MISALIGN_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [REG_AW-1:0]   wd_i,
  input  logic                wreg_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [1:0]          mem_op_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   reg2_i,
  output logic                stall_o,
  output logic                valid_o,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [REG_AW-1:0]   mem_wd_o,
  output logic                mem_wreg_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic                misalign_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [DATA_W-1:0]   mem_data_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int B  = DATA_W / 8;
  localparam int OW = $clog2(B);
  localparam int CW = OW + 1;
  localparam int W2 = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] B_ADDR = ADDR_W'(B);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ1 = 2'd1,
    REQ2 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [REG_AW-1:0] wd_q;
  logic              wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic              store_q;
  logic [CW-1:0]     size_n_q;
  logic              uns_q;
  logic [OW-1:0]     off_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              split_q;
  logic [DATA_W-1:0] reg2_q;
  logic [DATA_W-1:0] hold_q;

  logic              is_mem_in;
  logic [CW-1:0]     nbytes_in;
  logic [OW-1:0]     off_in;
  logic              aligned_in;
  logic              cross_in;
  logic              fault_in;
  logic              accept;
  logic              last_txn;

  // Input decode for the accept cycle
  always_comb begin
    case (size_i)
      2'b00:   nbytes_in = CW'(1);
      2'b01:   nbytes_in = CW'(2);
      2'b10:   nbytes_in = CW'(4);
      default: nbytes_in = CW'(B);
    endcase
  end

  assign off_in     = mem_addr_i[OW-1:0];
  assign is_mem_in  = (mem_op_i == 2'b01) || (mem_op_i == 2'b10);
  assign aligned_in = (({1'b0, off_in}) & (nbytes_in - CW'(1))) == '0;
  assign cross_in   = ({2'b00, off_in} + {1'b0, nbytes_in}) > (CW+1)'(B);
  assign fault_in   = (MISALIGN_EN == 0) && !aligned_in;
  assign accept     = (state_q == IDLE) && valid_i && is_mem_in;
  assign last_txn   = (state_q == REQ2) || ((state_q == REQ1) && !split_q);

  // Lane placement works on a two-word window {lower word, upper word} so split and
  // single accesses share one datapath; byte offset 0 is the most significant byte.
  logic [CW-1:0]     pad_bytes;
  logic [CW+2:0]     sh_pad;
  logic [OW+2:0]     sh_off;
  logic [2*B-1:0]    sel_base;
  logic [2*B-1:0]    sel_wide;
  logic [W2-1:0]     st_base;
  logic [W2-1:0]     st_wide;
  logic [W2-1:0]     ld_wide;
  logic [W2-1:0]     ld_shift;
  logic [DATA_W-1:0] ld_top;
  logic [DATA_W-1:0] ld_mask;
  logic [DATA_W-1:0] ld_result;

  always_comb begin
    pad_bytes = CW'(B) - size_n_q;
    sh_pad    = {pad_bytes, 3'b000};
    sh_off    = {off_q, 3'b000};
    sel_base  = {{B{1'b1}}, {B{1'b0}}};
    sel_wide  = (sel_base << pad_bytes) >> off_q;
    st_base   = {reg2_q, {DATA_W{1'b0}}};
    st_wide   = (st_base << sh_pad) >> sh_off;
    if (state_q == REQ2) ld_wide = {hold_q, mem_rdata_i};
    else                 ld_wide = {mem_rdata_i, {DATA_W{1'b0}}};
    ld_shift  = ld_wide << sh_off;
    ld_top    = ld_shift[W2-1 -: DATA_W];
    ld_mask   = {DATA_W{1'b1}} >> sh_pad;
    // ld_top still holds the value MS-aligned, so its top bit is the sign bit
    ld_result = (ld_top >> sh_pad) | (~ld_mask & {DATA_W{ld_top[DATA_W-1] & ~uns_q}});
  end

  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_sel_o  = '0;
    mem_data_o = '0;
    if (state_q == REQ1 || state_q == REQ2) begin
      mem_req_o = 1'b1;
      mem_we_o  = store_q;
      if (state_q == REQ2) begin
        mem_addr_o = waddr_q + B_ADDR;
        mem_sel_o  = sel_wide[B-1:0];
        mem_data_o = store_q ? st_wide[DATA_W-1:0] : '0;
      end else begin
        mem_addr_o = waddr_q;
        mem_sel_o  = sel_wide[2*B-1:B];
        mem_data_o = store_q ? st_wide[W2-1:DATA_W] : '0;
      end
    end
  end

  // A faulting access resolves in its accept cycle, so it must not hold upstream
  // or the same instruction would be presented again.
  always_comb begin
    stall_o = 1'b0;
    if (accept && !fault_in)  stall_o = 1'b1;
    else if (state_q != IDLE) stall_o = !(mem_ack_i && last_txn);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !fault_in) state_d = REQ1;
      REQ1:    if (mem_ack_i) state_d = split_q ? REQ2 : IDLE;
      REQ2:    if (mem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_o    <= 1'b0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      wdata_o    <= '0;
      misalign_o <= 1'b0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      size_n_q   <= '0;
      uns_q      <= 1'b0;
      off_q      <= '0;
      waddr_q    <= '0;
      split_q    <= 1'b0;
      reg2_q     <= '0;
      hold_q     <= '0;
    end else begin
      valid_o    <= 1'b0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      wdata_o    <= '0;
      misalign_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (!is_mem_in) begin
              valid_o <= 1'b1;
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
              wdata_o <= wdata_i;
            end else if (fault_in) begin
              valid_o    <= 1'b1;
              wd_o       <= wd_i;
              misalign_o <= 1'b1;
            end else begin
              wd_q     <= wd_i;
              wreg_q   <= wreg_i;
              wdata_q  <= wdata_i;
              store_q  <= (mem_op_i == 2'b10);
              size_n_q <= nbytes_in;
              uns_q    <= unsigned_i;
              off_q    <= off_in;
              waddr_q  <= {mem_addr_i[ADDR_W-1:OW], {OW{1'b0}}};
              split_q  <= cross_in;
              reg2_q   <= reg2_i;
            end
          end
        end
        REQ1, REQ2: begin
          if (mem_ack_i) begin
            if (last_txn) begin
              valid_o <= 1'b1;
              wd_o    <= wd_q;
              wreg_o  <= wreg_q;
              wdata_o <= store_q ? wdata_q : ld_result;
            end else begin
              hold_q <= mem_rdata_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_wd_o    = wd_o;
  assign mem_wreg_o  = wreg_o;
  assign mem_wdata_o = wdata_o;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table on a MISALIGN_EN=1 instance plus hand sequences
// for reset abort and the MISALIGN_EN=0 fault path; wb results checked through a scoreboard.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid_i, valid0_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [1:0]  mem_op_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic        mem_ack_i, ack0_i;
  logic [31:0] mem_rdata_i;

  logic        stall_o, valid_o, wreg_o, mem_wreg_o, misalign_o, mem_req_o, mem_we_o;
  logic [4:0]  wd_o, mem_wd_o;
  logic [31:0] wdata_o, mem_wdata_o, mem_addr_o, mem_data_o;
  logic [3:0]  mem_sel_o;

  logic        stall0, v0_o, wreg0_o, mwreg0, mis0, req0, we0;
  logic [4:0]  wd0_o, mwd0;
  logic [31:0] wdata0_o, mwdata0, addr0, data0;
  logic [3:0]  sel0;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .MISALIGN_EN(1)) u_dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .size_i(size_i), .unsigned_i(unsigned_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .stall_o(stall_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
    .misalign_o(misalign_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .MISALIGN_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .valid_i(valid0_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .size_i(size_i), .unsigned_i(unsigned_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .stall_o(stall0), .valid_o(v0_o), .wd_o(wd0_o), .wreg_o(wreg0_o),
    .wdata_o(wdata0_o), .mem_wd_o(mwd0), .mem_wreg_o(mwreg0), .mem_wdata_o(mwdata0),
    .misalign_o(mis0), .mem_req_o(req0), .mem_we_o(we0), .mem_addr_o(addr0),
    .mem_sel_o(sel0), .mem_data_o(data0), .mem_ack_i(ack0_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] alu;
    logic [4:0]  wd;
    logic        wreg;
    int          waits;
    logic [31:0] rd1, rd2;
    logic        split;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] d1;
    logic [31:0] a2;
    logic [3:0]  s2;
    logic [31:0] d2;
    logic [31:0] exp_w;
  } vec_t;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];
  exp_t me, me0;
  vec_t vt[12];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] reg2, input logic [31:0] alu,
                              input logic [4:0] wd, input logic wreg, input int waits,
                              input logic [31:0] rd1, input logic [31:0] rd2, input logic split,
                              input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                              input logic [31:0] a2, input logic [3:0] s2, input logic [31:0] d2,
                              input logic [31:0] exp_w);
    vec_t v;
    v.op = op; v.size = size; v.uns = uns; v.addr = addr; v.reg2 = reg2; v.alu = alu;
    v.wd = wd; v.wreg = wreg; v.waits = waits; v.rd1 = rd1; v.rd2 = rd2; v.split = split;
    v.a1 = a1; v.s1 = s1; v.d1 = d1; v.a2 = a2; v.s2 = s2; v.d2 = d2; v.exp_w = exp_w;
    return v;
  endfunction

  // wb-side scoreboard for the split-capable instance
  always @(negedge clk) begin
    #2;
    if (valid_o === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got valid_o=1 required 0 (cycle %0d)", cyc);
      end else begin
        me = q.pop_front();
        chk("wd_o", 64'(wd_o), 64'(me.wd));
        chk("wreg_o", 64'(wreg_o), 64'(me.wreg));
        chk("wdata_o", 64'(wdata_o), 64'(me.wdata));
        chk("misalign_o", 64'(misalign_o), 64'(me.mis));
        chk("fwd_wd", 64'(mem_wd_o), 64'(me.wd));
        chk("fwd_wreg", 64'(mem_wreg_o), 64'(me.wreg));
        chk("fwd_wdata", 64'(mem_wdata_o), 64'(me.wdata));
        chk("latency", 64'(cyc), 64'(me.cyc));
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (v0_o === 1'b1) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid0: got valid_o=1 required 0 (cycle %0d)", cyc);
      end else begin
        me0 = q0.pop_front();
        chk("wd0_o", 64'(wd0_o), 64'(me0.wd));
        chk("wreg0_o", 64'(wreg0_o), 64'(me0.wreg));
        chk("wdata0_o", 64'(wdata0_o), 64'(me0.wdata));
        chk("misalign0_o", 64'(mis0), 64'(me0.mis));
        chk("fwd0_wdata", 64'(mwdata0), 64'(me0.wdata));
        chk("latency0", 64'(cyc), 64'(me0.cyc));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   start;
    int   ntx;
    logic is_mem;
    exp_t e;
    is_mem = (v.op == 2'b01) || (v.op == 2'b10);
    ntx    = v.split ? 2 : 1;
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = v.op; size_i = v.size; unsigned_i = v.uns; mem_addr_i = v.addr;
    reg2_i = v.reg2; wdata_i = v.alu; wd_i = v.wd; wreg_i = v.wreg; mem_ack_i = 1'b0;
    start   = cyc;
    e.wd    = v.wd;
    e.wreg  = v.wreg;
    e.wdata = v.exp_w;
    e.mis   = 1'b0;
    e.cyc   = is_mem ? start + 2 + v.waits + (v.split ? 1 + v.waits : 0) : start + 1;
    q.push_back(e);
    #1 chk("accept_stall", 64'(stall_o), 64'(is_mem));
    if (is_mem) begin
      for (int t = 0; t < ntx; t++) begin
        for (int w = 0; w <= v.waits; w++) begin
          @(negedge clk);
          mem_ack_i = 1'b0;
          #1;
          chk("req", 64'(mem_req_o), 64'd1);
          chk("we", 64'(mem_we_o), 64'(v.op == 2'b10));
          chk("addr", 64'(mem_addr_o), 64'((t == 1) ? v.a2 : v.a1));
          chk("sel", 64'(mem_sel_o), 64'((t == 1) ? v.s2 : v.s1));
          if (v.op == 2'b10) chk("st_data", 64'(mem_data_o), 64'((t == 1) ? v.d2 : v.d1));
          if (w < v.waits) begin
            chk("wait_stall", 64'(stall_o), 64'd1);
          end else begin
            mem_rdata_i = (t == 1) ? v.rd2 : v.rd1;
            mem_ack_i   = 1'b1;
            #1 chk("ack_stall", 64'(stall_o), 64'(t != ntx - 1));
          end
        end
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
      valid_i   = 1'b0;
      #1 chk("req_drop", 64'(mem_req_o), 64'd0);
    end
  endtask

  task automatic fault_case(input logic [1:0] op, input logic [1:0] size, input logic [31:0] addr,
                            input logic [4:0] wd);
    exp_t e;
    @(negedge clk);
    valid0_i = 1'b1; mem_op_i = op; size_i = size; mem_addr_i = addr; wd_i = wd; wreg_i = 1'b1;
    e.wd = wd; e.wreg = 1'b0; e.wdata = 32'h0; e.mis = 1'b1; e.cyc = cyc + 1;
    q0.push_back(e);
    #1 chk("f_req_accept", 64'(req0), 64'd0);
    @(negedge clk);
    valid0_i = 1'b0;
    #1 chk("f_req_next", 64'(req0), 64'd0);
    @(negedge clk);
    #1;
    chk("f_req_later", 64'(req0), 64'd0);
    chk("f_mis_pulse", 64'(mis0), 64'd0);
    chk("f_valid_pulse", 64'(v0_o), 64'd0);
  endtask

  initial begin
    exp_t e;
    vt[0]  = mk(2'b00, 2'b00, 1'b0, 32'h0,    32'h0,        32'hCAFEF00D, 5'd3,  1'b1, 0, 32'h0,        32'h0,        1'b0, 32'h0,    4'b0000, 32'h0,        32'h0,    4'b0000, 32'h0,        32'hCAFEF00D);
    vt[1]  = mk(2'b01, 2'b00, 1'b0, 32'h1001, 32'h0,        32'h0,        5'd4,  1'b1, 2, 32'h11803344, 32'h0,        1'b0, 32'h1000, 4'b0100, 32'h0,        32'h0,    4'b0000, 32'h0,        32'hFFFFFF80);
    vt[2]  = mk(2'b01, 2'b01, 1'b1, 32'h2002, 32'h0,        32'h0,        5'd5,  1'b1, 0, 32'hAAAABEEF, 32'h0,        1'b0, 32'h2000, 4'b0011, 32'h0,        32'h0,    4'b0000, 32'h0,        32'h0000BEEF);
    vt[3]  = mk(2'b01, 2'b10, 1'b0, 32'h3003, 32'h0,        32'h0,        5'd6,  1'b1, 1, 32'h000000DE, 32'hADBEEF00, 1'b1, 32'h3000, 4'b0001, 32'h0,        32'h3004, 4'b1110, 32'h0,        32'hDEADBEEF);
    vt[4]  = mk(2'b10, 2'b10, 1'b0, 32'h3003, 32'h12345678, 32'h55,       5'd0,  1'b0, 0, 32'h0,        32'h0,        1'b1, 32'h3000, 4'b0001, 32'h00000012, 32'h3004, 4'b1110, 32'h34567800, 32'h55);
    vt[5]  = mk(2'b10, 2'b00, 1'b0, 32'h4002, 32'hFFFFFFA5, 32'h0,        5'd1,  1'b0, 1, 32'h0,        32'h0,        1'b0, 32'h4000, 4'b0010, 32'h0000A500, 32'h0,    4'b0000, 32'h0,        32'h0);
    vt[6]  = mk(2'b01, 2'b01, 1'b0, 32'h5001, 32'h0,        32'h0,        5'd7,  1'b1, 0, 32'h00F00100, 32'h0,        1'b0, 32'h5000, 4'b0110, 32'h0,        32'h0,    4'b0000, 32'h0,        32'hFFFFF001);
    vt[7]  = mk(2'b01, 2'b00, 1'b1, 32'h6003, 32'h0,        32'h0,        5'd8,  1'b1, 0, 32'h000000FE, 32'h0,        1'b0, 32'h6000, 4'b0001, 32'h0,        32'h0,    4'b0000, 32'h0,        32'h000000FE);
    vt[8]  = mk(2'b11, 2'b10, 1'b0, 32'h0,    32'h0,        32'h1234,     5'd9,  1'b1, 0, 32'h0,        32'h0,        1'b0, 32'h0,    4'b0000, 32'h0,        32'h0,    4'b0000, 32'h0,        32'h1234);
    vt[9]  = mk(2'b10, 2'b01, 1'b0, 32'h7003, 32'h1234BEEF, 32'h77,       5'd2,  1'b1, 0, 32'h0,        32'h0,        1'b1, 32'h7000, 4'b0001, 32'h000000BE, 32'h7004, 4'b1000, 32'hEF000000, 32'h77);
    vt[10] = mk(2'b01, 2'b10, 1'b0, 32'h8004, 32'h0,        32'h0,        5'd10, 1'b1, 3, 32'h89ABCDEF, 32'h0,        1'b0, 32'h8004, 4'b1111, 32'h0,        32'h0,    4'b0000, 32'h0,        32'h89ABCDEF);
    vt[11] = mk(2'b01, 2'b01, 1'b0, 32'h9003, 32'h0,        32'h0,        5'd11, 1'b1, 0, 32'h000000C0, 32'h11FFFFFF, 1'b1, 32'h9000, 4'b0001, 32'h0,        32'h9004, 4'b1000, 32'h0,        32'hFFFFC011);

    rst = 1'b0; valid_i = 1'b0; valid0_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    mem_op_i = 2'b00; size_i = 2'b00; unsigned_i = 1'b0; mem_addr_i = '0; reg2_i = '0;
    mem_ack_i = 1'b0; ack0_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_wreg", 64'(wreg_o), 64'd0);
    chk("rst_wdata", 64'(wdata_o), 64'd0);
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_mis", 64'(misalign_o), 64'd0);
    chk("rst_valid0", 64'(v0_o), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vt[i]);

    // Idle after an ALU result clears the wb/forwarding outputs
    run_vec(vt[0]);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_valid", 64'(valid_o), 64'd0);
    chk("idle_wreg", 64'(wreg_o), 64'd0);
    chk("idle_wdata", 64'(wdata_o), 64'd0);
    chk("idle_fwd_wreg", 64'(mem_wreg_o), 64'd0);

    // Reset while REQ1 is outstanding, then a stray ack
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = 2'b01; size_i = 2'b10; unsigned_i = 1'b0; mem_addr_i = 32'h8000;
    wd_i = 5'd13; wreg_i = 1'b1;
    @(negedge clk);
    #1 chk("abort_req_up", 64'(mem_req_o), 64'd1);
    rst = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    #1;
    chk("abort_req", 64'(mem_req_o), 64'd0);
    chk("abort_stall", 64'(stall_o), 64'd0);
    chk("abort_valid", 64'(valid_o), 64'd0);
    chk("abort_wdata", 64'(wdata_o), 64'd0);
    chk("abort_sel", 64'(mem_sel_o), 64'd0);
    chk("abort_addr", 64'(mem_addr_o), 64'd0);
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    chk("abort_ack_ignored", 64'(valid_o), 64'd0);
    chk("abort_req_after", 64'(mem_req_o), 64'd0);
    run_vec(vt[8]);
    @(negedge clk);
    valid_i = 1'b0;

    // Instance without splitting: unaligned faults, aligned goes to the bus
    fault_case(2'b01, 2'b01, 32'h0000_0001, 5'd14);
    fault_case(2'b01, 2'b10, 32'h0000_0002, 5'd15);
    fault_case(2'b10, 2'b10, 32'h0000_0005, 5'd16);
    @(negedge clk);
    valid0_i = 1'b1; mem_op_i = 2'b01; size_i = 2'b01; unsigned_i = 1'b0; mem_addr_i = 32'h0000_0002;
    wd_i = 5'd12; wreg_i = 1'b1;
    e.wd = 5'd12; e.wreg = 1'b1; e.wdata = 32'hFFFFABCD; e.mis = 1'b0; e.cyc = cyc + 2;
    q0.push_back(e);
    #1 chk("al0_accept_stall", 64'(stall0), 64'd1);
    @(negedge clk);
    #1;
    chk("al0_req", 64'(req0), 64'd1);
    chk("al0_sel", 64'(sel0), 64'(4'b0011));
    chk("al0_addr", 64'(addr0), 64'd0);
    mem_rdata_i = 32'h1234ABCD;
    ack0_i = 1'b1;
    #1 chk("al0_ack_stall", 64'(stall0), 64'd0);
    @(negedge clk);
    ack0_i = 1'b0; valid0_i = 1'b0;

    repeat (3) @(negedge clk);
    #3;
    chk("drain", 64'(q.size()), 64'd0);
    chk("drain0", 64'(q0.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
